// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: turns EX/MEM accesses into handshaked bus transactions,
// stalls the upstream pipeline while one is outstanding, and abandons it after TIMEOUT cycles.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        req_valid,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic        StallM,
  output logic        RegWriteGM,
  output logic [31:0] ReadDataM,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        bus_err_q, bus_err_d;
  logic        access;
  logic        expired;

  assign access  = MemReadM | MemWriteM;
  assign expired = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    read_data_d = read_data_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d     = StReq;
          cnt_d       = 8'd0;
          req_valid_d = 1'b1;
          req_we_d    = MemWriteM;
          req_addr_d  = ALUResultM;
          req_wdata_d = WriteDataM;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        // A store completes on handshake; a load handshake only opens RESP, so timeout wins.
        if (req_ready && req_we_q) begin
          req_valid_d = 1'b0;
          state_d     = StDone;
        end else if (expired) begin
          req_valid_d = 1'b0;
          bus_err_d   = 1'b1;
          if (!req_we_q) read_data_d = ERR_DATA;
          state_d     = StDone;
        end else if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        cnt_d = cnt_q + 8'd1;
        if (resp_valid) begin
          read_data_d = resp_rdata;
          state_d     = StDone;
        end else if (expired) begin
          bus_err_d   = 1'b1;
          read_data_d = ERR_DATA;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      read_data_q <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Stall is forced low during reset so the pipeline is not held by a stale access.
  assign StallM     = rst_n & (((state_q == StIdle) & access) |
                               (state_q == StReq) | (state_q == StResp));
  assign RegWriteGM = RegWriteM & (((state_q == StIdle) & ~access) | (state_q == StDone));

  assign req_valid  = req_valid_q;
  assign req_we     = req_we_q;
  assign req_addr   = req_addr_q;
  assign req_wdata  = req_wdata_q;
  assign ReadDataM  = read_data_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table of access vectors against a small bus
// responder, expected results queued at drive time and compared at completion.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, RegWriteM = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready = 1'b0, resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        StallM, RegWriteGM, bus_err;
  logic [31:0] ReadDataM;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .RegWriteM  (RegWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .StallM     (StallM),
    .RegWriteGM (RegWriteGM),
    .ReadDataM  (ReadDataM),
    .bus_err    (bus_err)
  );

  // rdy_dly/resp_dly = 255 means the bus never answers.
  typedef struct {
    logic        rd, wr, rw;
    logic [31:0] addr, wdata, rdata;
    int          rdy_dly, resp_dly;
    int          exp_stall, exp_req;
    logic        exp_gm, exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          stall;
    int          req;
    logic        gm;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[11];

  function automatic vec_t mk(logic rd, logic wr, logic rw, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int rdy, int resp,
                              int stall, int reqc, logic gm, logic err, logic [31:0] exp_rd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rdy_dly = rdy; v.resp_dly = resp; v.exp_stall = stall; v.exp_req = reqc;
    v.exp_gm = gm; v.exp_err = err; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   stall = 0;
    int   reqc = 0;
    int   rdy_wait = 0;
    int   resp_wait = 0;
    int   first_req = -1;
    bit   wait_resp = 0;
    bit   done = 0;
    exp_t e;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    RegWriteM  = v.rw;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    resp_rdata = v.rdata;
    exp_q.push_back('{v.exp_stall, v.exp_req, v.exp_gm, v.exp_err, v.exp_rd});
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      if (!StallM) begin
        done = 1;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL v%0d scoreboard: got empty queue, expected an entry", idx);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d stall_cycles", idx), 32'(stall), 32'(e.stall));
          check($sformatf("v%0d req_cycles", idx), 32'(reqc), 32'(e.req));
          check($sformatf("v%0d RegWriteGM", idx), 32'(RegWriteGM), 32'(e.gm));
          check($sformatf("v%0d ReadDataM", idx), ReadDataM, e.rd);
          check($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(e.err));
          check($sformatf("v%0d req_valid_done", idx), 32'(req_valid), 32'd0);
          // The detect cycle is always the cycle after the previous DONE.
          if (e.req > 0) check($sformatf("v%0d req_rise", idx), 32'(first_req), 32'd1);
        end
      end else begin
        stall++;
        check($sformatf("v%0d gm_in_stall", idx), 32'(RegWriteGM), 32'd0);
        if (req_valid) begin
          reqc++;
          if (first_req < 0) first_req = cyc;
          check($sformatf("v%0d req_we", idx), 32'(req_we), 32'(v.wr));
          check($sformatf("v%0d req_addr", idx), req_addr, v.addr);
          check($sformatf("v%0d req_wdata", idx), req_wdata, v.wdata);
          if (rdy_wait >= v.rdy_dly) begin
            req_ready = 1'b1;
            wait_resp = v.rd & ~v.wr;
          end else begin
            rdy_wait++;
          end
        end else if (wait_resp) begin
          if (resp_wait == v.resp_dly) resp_valid = 1'b1;
          resp_wait++;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d completion: got no DONE in 64 cycles, expected completion", idx);
    end
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    RegWriteM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench to end");
    $fatal(1);
  end

  initial begin
    //                 rd  wr  rw  addr          wdata         rdata        rdy  resp stl req gm err exp_rd
    vecs[0]  = mk(1'b0,1'b0,1'b1,32'h0,        32'h0,        32'h0,        0,   0,  0,  0, 1, 0, 32'h0);
    vecs[1]  = mk(1'b0,1'b0,1'b0,32'h4,        32'h0,        32'h0,        0,   0,  0,  0, 0, 0, 32'h0);
    vecs[2]  = mk(1'b1,1'b0,1'b1,32'h100,      32'h0,        32'h12345678, 0,   0,  3,  1, 1, 0, 32'h12345678);
    vecs[3]  = mk(1'b0,1'b1,1'b0,32'h40,       32'hCAFEF00D, 32'h0,        3,   0,  5,  4, 0, 0, 32'h12345678);
    vecs[4]  = mk(1'b1,1'b0,1'b1,32'h200,      32'h77,       32'hA5A50001, 2,   1,  6,  3, 1, 0, 32'hA5A50001);
    vecs[5]  = mk(1'b1,1'b0,1'b1,32'h204,      32'h0,        32'h0BADF00D, 0,  14, 17,  1, 1, 0, 32'h0BADF00D);
    vecs[6]  = mk(1'b1,1'b1,1'b0,32'h80,       32'h13572468, 32'hFFFFFFFF, 1,   0,  3,  2, 0, 0, 32'h0BADF00D);
    vecs[7]  = mk(1'b1,1'b0,1'b1,32'h300,      32'h0,        32'h0,        0, 255, 17,  1, 1, 1, 32'hDEADBEEF);
    vecs[8]  = mk(1'b1,1'b0,1'b1,32'h304,      32'h0,        32'h11112222, 0,   0,  3,  1, 1, 1, 32'h11112222);
    vecs[9]  = mk(1'b0,1'b1,1'b0,32'h308,      32'h99,       32'h0,      255,   0, 17, 16, 0, 1, 32'h11112222);
    vecs[10] = mk(1'b0,1'b0,1'b1,32'h0,        32'h0,        32'h0,        0,   0,  0,  0, 1, 1, 32'h11112222);

    repeat (2) @(negedge clk);
    check("rst req_valid", 32'(req_valid), 32'd0);
    check("rst req_we", 32'(req_we), 32'd0);
    check("rst req_addr", req_addr, 32'd0);
    check("rst req_wdata", req_wdata, 32'd0);
    check("rst ReadDataM", ReadDataM, 32'd0);
    check("rst bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset pulse while a load waits in RESP; a late response must be discarded.
    MemReadM   = 1'b1;
    RegWriteM  = 1'b1;
    ALUResultM = 32'h400;
    @(negedge clk);
    check("rr detect stall", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr req_valid", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    check("rr in resp stall", 32'(StallM), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rr rst req_valid", 32'(req_valid), 32'd0);
    check("rr rst StallM", 32'(StallM), 32'd0);
    check("rr rst bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    check("rr rst StallM held", 32'(StallM), 32'd0);
    @(negedge clk);
    MemReadM  = 1'b0;
    RegWriteM = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b1;
    resp_rdata = 32'h55555555;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    check("rr late ReadDataM", ReadDataM, 32'd0);
    check("rr late StallM", 32'(StallM), 32'd0);
    check("rr late req_valid", 32'(req_valid), 32'd0);
    check("rr late bus_err", 32'(bus_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the 5-stage RISC pipeline. It sits between the EX/MEM pipeline register and a handshaked data-memory bus. It sequences each load/store as a bus transaction and freezes the upstream pipeline while the access is outstanding. While frozen it feeds bubbles into the MEM/WB register, then presents the load data and the original write-enable for exactly one cycle on completion.

## Interface

Parameters:
- TIMEOUT, 16, cycles allowed in REQ+RESP before the access is abandoned (2..255)
- ERR_DATA, 32'hDEADBEEF, value returned as load data on timeout

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- RegWriteM  in  1  register write-enable of MEM-stage instruction
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data
- req_valid  out  1  bus request valid (registered)
- req_we  out  1  1 = write (registered)
- req_addr  out  32  request address (registered)
- req_wdata  out  32  write data (registered)
- req_ready  in  1  bus accepts request
- resp_valid  in  1  read data valid
- resp_rdata  in  32  read data
- StallM  out  1  hold PC and IF/ID, ID/EX, EX/MEM registers (combinational)
- RegWriteGM  out  1  gated RegWriteM into MEM/WB register
- ReadDataM  out  32  load data into MEM/WB register
- bus_err  out  1  sticky timeout flag

## Operation

- States: IDLE, REQ, RESP, DONE. Reset state IDLE. Reset values: req_valid=0, req_we=0, req_addr=0, req_wdata=0, ReadDataM=0, bus_err=0, timeout counter=0.
- access = MemReadM | MemWriteM. If both are set, the access is treated as a store.
- IDLE: with access=1, register req_addr=ALUResultM, req_wdata=WriteDataM, req_we=MemWriteM, req_valid=1, and go to REQ. Otherwise stay in IDLE.
- REQ: hold all req_* stable while req_valid=1 and req_ready=0. On req_valid&req_ready, clear req_valid. A store then goes to DONE; a load goes to RESP.
- RESP: on resp_valid, capture ReadDataM=resp_rdata and go to DONE. resp_valid is ignored in every other state.
- Timeout: the counter clears on IDLE→REQ and increments each cycle in REQ or RESP. If it reaches TIMEOUT-1 without completion, the controller:
  - clears req_valid
  - sets ReadDataM=ERR_DATA (loads only)
  - sets bus_err=1
  - goes to DONE
- bus_err stays set until reset.
- DONE: go unconditionally to IDLE.
- StallM = (IDLE & access) | REQ | RESP. It is 0 in DONE.
- RegWriteGM = RegWriteM when (IDLE & ~access) or DONE. It is 0 while StallM=1, which injects a bubble into MEM/WB.
- ReadDataM holds its value outside RESP capture and the timeout path. Stores leave it unchanged.
- Async reset in any state returns to IDLE immediately. req_valid drops without waiting for req_ready, and an in-flight response is discarded.

## Timing

- Zero-wait bus (req_ready=1 in the first REQ cycle, resp_valid the next cycle):
  - Load: IDLE detect (c0) → REQ (c1) → RESP (c2) → DONE (c3). StallM=1 for c0–c2 (3 cycles), and the instruction is written into MEM/WB at the end of c3.
  - Store: c0 → REQ (c1) → DONE (c2), 2 stall cycles.
- Each cycle req_ready is low adds one cycle. Each cycle resp_valid is late adds one cycle.
- Back-to-back accesses: during DONE the next instruction advances into MEM. It is detected in the following IDLE cycle, so there is no overlap and at most one transaction is outstanding.
- Non-memory instructions pass with zero added latency (StallM=0, RegWriteGM=RegWriteM).
- Worst case with a timeout: TIMEOUT+2 cycles from detect to the DONE exit.

## Test plan

- ALU op (MemReadM=0, MemWriteM=0, RegWriteM=1): StallM=0 and RegWriteGM=1 in the same cycle; req_valid is never asserted.
- Load at 0x100, zero-wait bus returning 0x12345678: req_valid high for 1 cycle with req_addr=0x100 and req_we=0. StallM high for 3 cycles. In DONE, ReadDataM=0x12345678 and RegWriteGM=1; RegWriteGM=0 in all stall cycles.
- Store of 0xCAFEF00D to 0x40 with req_ready low for 3 cycles: req_* stable for 4 REQ cycles with req_we=1 and req_wdata=0xCAFEF00D. StallM high for 5 cycles; DONE follows, ReadDataM is unchanged, and bus_err=0.
- Load with resp_valid never asserted, TIMEOUT=16: DONE is reached 16 cycles after entering REQ. ReadDataM=0xDEADBEEF and bus_err=1, and bus_err stays 1 across later successful accesses until rst_n=0.
- Two consecutive loads: the second req_valid rises exactly 2 cycles after the first DONE cycle. Each load's ReadDataM appears in its own DONE cycle.
- rst_n pulsed low in the RESP state: req_valid=0, StallM=0 and state IDLE while reset is asserted. A resp_valid arriving after reset deasserts does not change ReadDataM (remains 0).
